// File: rtl/sram_pkg.sv
// Shared types and sizing helpers for the burst SRAM controller and its beat timer.
package sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DONE
    } state_t;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

    // Counter width that never collapses to zero bits for degenerate counts.
    function automatic int bits_for(input int count);
        return (clog2(count) < 1) ? 1 : clog2(count);
    endfunction

    function automatic int beats_of(input int cpu_w, input int sram_dw);
        return cpu_w / sram_dw;
    endfunction

    localparam int DEF_CPU_W     = 32;
    localparam int DEF_SRAM_DW   = 16;
    localparam int DEF_BURST_MAX = 4;
    localparam int BEATS         = beats_of(DEF_CPU_W, DEF_SRAM_DW);
    localparam int BEAT_CW       = bits_for(BEATS);
    localparam int WORD_CW       = bits_for(DEF_BURST_MAX);

endpackage

// File: rtl/sram_beat_timer.sv
// Wait-state and beat counter; flags the last cycle of each beat and of each CPU word.
module sram_beat_timer
    import sram_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int BEATS       = 2,
    parameter int BEAT_CW     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               enable,
    output logic               beat_last,
    output logic               word_last,
    output logic [BEAT_CW-1:0] beat_idx
);
    localparam int WAIT_CW = bits_for(WAIT_STATES + 1);

    logic [WAIT_CW-1:0] wait_reg;
    logic [BEAT_CW-1:0] beat_reg;

    assign beat_last = enable && (wait_reg == WAIT_CW'(WAIT_STATES));
    assign word_last = beat_last && (beat_reg == BEAT_CW'(BEATS - 1));
    assign beat_idx  = beat_reg;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wait_reg <= '0;
            beat_reg <= '0;
        end else if (enable) begin
            if (beat_last) begin
                wait_reg <= '0;
                beat_reg <= word_last ? '0 : beat_reg + 1'b1;
            end else begin
                wait_reg <= wait_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_burst_ctrl.sv
// Splits CPU words into SRAM beats with wait states; supports multi-word read bursts.
module sram_burst_ctrl
    import sram_pkg::*;
#(
    parameter int CPU_W       = 32,
    parameter int SRAM_DW     = 16,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_STATES = 1,
    parameter int BURST_MAX   = 4,
    parameter int BASE_ADDR   = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_rd,
    input  logic                          req_wr,
    input  logic [CPU_W-1:0]              req_addr,
    input  logic [CPU_W-1:0]              req_wdata,
    input  logic [bits_for(BURST_MAX):0]  req_len,
    output logic                          busy,
    output logic                          done,
    output logic [CPU_W-1:0]              rdata,
    output logic                          rdata_valid,
    output logic [bits_for(BURST_MAX)-1:0] word_idx,
    inout  wire  [SRAM_DW-1:0]            SRAM_DQ,
    output logic [SRAM_AW-1:0]            SRAM_ADDR,
    output logic                          SRAM_WE_N,
    output logic                          SRAM_OE_N
);
    localparam int BEATS      = beats_of(CPU_W, SRAM_DW);
    localparam int BEAT_CW    = bits_for(BEATS);
    localparam int WORD_CW    = bits_for(BURST_MAX);
    localparam int LEN_W      = WORD_CW + 1;
    localparam int BYTE_SHIFT = clog2(CPU_W / 8);

    state_t             state_reg, state_next;
    logic [SRAM_AW-1:0] wa_reg;
    logic [CPU_W-1:0]   wdata_reg, asm_reg, asm_next, rdata_reg, req_addr_off;
    logic [WORD_CW-1:0] word_reg, last_word_reg, word_idx_reg, len_last;
    logic [LEN_W-1:0]   len_eff;
    logic               rdata_valid_reg;
    logic               timer_clear, timer_en, beat_last, word_last, dq_drive;
    logic [BEAT_CW-1:0] beat_idx;
    logic [SRAM_DW-1:0] wbeat_arr [BEATS];
    logic               unused_addr_bits;

    // Only the word-address bits that reach the SRAM matter; wrap-around is modular.
    assign req_addr_off     = req_addr - CPU_W'(BASE_ADDR);
    assign unused_addr_bits = ^{req_addr_off[CPU_W-1:BYTE_SHIFT+SRAM_AW],
                                req_addr_off[BYTE_SHIFT-1:0]};

    always_comb begin
        len_eff = req_len;
        if (req_len == '0) begin
            len_eff = LEN_W'(1);
        end else if (req_len > LEN_W'(BURST_MAX)) begin
            len_eff = LEN_W'(BURST_MAX);
        end
    end
    assign len_last = WORD_CW'(len_eff - LEN_W'(1));

    sram_beat_timer #(
        .WAIT_STATES (WAIT_STATES),
        .BEATS       (BEATS),
        .BEAT_CW     (BEAT_CW)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (timer_clear),
        .enable    (timer_en),
        .beat_last (beat_last),
        .word_last (word_last),
        .beat_idx  (beat_idx)
    );

    assign timer_clear = (state_reg == ST_IDLE) || (state_reg == ST_DONE);

    // The final beat bypasses asm_reg so rdata loads on that same edge.
    genvar gi;
    for (gi = 0; gi < BEATS; gi++) begin : g_beat
        assign asm_next[gi*SRAM_DW +: SRAM_DW] = (beat_idx == BEAT_CW'(gi)) ?
                                                 SRAM_DQ : asm_reg[gi*SRAM_DW +: SRAM_DW];
        assign wbeat_arr[gi] = wdata_reg[gi*SRAM_DW +: SRAM_DW];
    end

    assign SRAM_DQ   = dq_drive ? wbeat_arr[beat_idx] : {SRAM_DW{1'bz}};
    assign SRAM_ADDR = (wa_reg + SRAM_AW'(word_reg)) * SRAM_AW'(BEATS) + SRAM_AW'(beat_idx);

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        SRAM_WE_N  = 1'b1;
        SRAM_OE_N  = 1'b1;
        dq_drive   = 1'b0;
        timer_en   = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                busy = req_rd | req_wr;
                if (req_wr) begin
                    state_next = ST_WR;
                end else if (req_rd) begin
                    state_next = ST_RD;
                end
            end
            ST_WR: begin
                busy      = 1'b1;
                SRAM_WE_N = 1'b0;
                dq_drive  = 1'b1;
                timer_en  = 1'b1;
                if (word_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_RD: begin
                busy      = 1'b1;
                SRAM_OE_N = 1'b0;
                timer_en  = 1'b1;
                if (word_last && (word_reg == last_word_reg)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        // Reset aborts the access at once, not only at the next edge.
        if (!rst) begin
            busy      = 1'b0;
            done      = 1'b0;
            SRAM_WE_N = 1'b1;
            SRAM_OE_N = 1'b1;
            dq_drive  = 1'b0;
            timer_en  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            wa_reg          <= '0;
            wdata_reg       <= '0;
            last_word_reg   <= '0;
            word_reg        <= '0;
            asm_reg         <= '0;
            rdata_reg       <= '0;
            rdata_valid_reg <= 1'b0;
            word_idx_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            rdata_valid_reg <= 1'b0;
            if (state_reg == ST_IDLE) begin
                word_reg <= '0;
                if (req_rd || req_wr) begin
                    wa_reg        <= req_addr_off[BYTE_SHIFT +: SRAM_AW];
                    wdata_reg     <= req_wdata;
                    last_word_reg <= req_wr ? '0 : len_last;
                end
            end
            if ((state_reg == ST_RD) && beat_last) begin
                asm_reg <= asm_next;
            end
            if ((state_reg == ST_RD) && word_last) begin
                rdata_reg       <= asm_next;
                rdata_valid_reg <= 1'b1;
                word_idx_reg    <= word_reg;
                word_reg        <= word_reg + 1'b1;
            end
        end
    end

    assign rdata       = rdata_reg;
    assign rdata_valid = rdata_valid_reg;
    assign word_idx    = word_idx_reg;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Directed bench: one controller with one wait state, one with none, each on its own SRAM model.
module tb_sram_burst_ctrl;

    logic        clk;
    logic        rst_a, rst_b, use_b;
    logic        req_rd, req_wr;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_len;

    logic        busy_a, done_a, valid_a, we_n_a, oe_n_a;
    logic        busy_b, done_b, valid_b, we_n_b, oe_n_b;
    logic [31:0] rdata_a, rdata_b;
    logic [1:0]  widx_a, widx_b;
    logic [17:0] addr_a, addr_b;
    wire  [15:0] sram_dq_a, sram_dq_b;

    logic        o_busy, o_done, o_valid, o_we_n, o_oe_n;
    logic [31:0] o_rdata;
    logic [1:0]  o_widx;
    logic [17:0] o_addr;
    logic [15:0] o_dq;

    logic [15:0] mem_a [0:262143];
    logic [15:0] mem_b [0:262143];
    logic        pre_en, tb_drv_a;
    logic [17:0] pre_addr;
    logic [15:0] pre_data;
    logic [31:0] exp_w [4];

    int checks;
    int errors;

    sram_burst_ctrl #(
        .CPU_W(32), .SRAM_DW(16), .SRAM_AW(18), .WAIT_STATES(1), .BURST_MAX(4), .BASE_ADDR(1024)
    ) dut_a (
        .clk(clk), .rst(rst_a), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_len(req_len), .busy(busy_a), .done(done_a),
        .rdata(rdata_a), .rdata_valid(valid_a), .word_idx(widx_a), .SRAM_DQ(sram_dq_a),
        .SRAM_ADDR(addr_a), .SRAM_WE_N(we_n_a), .SRAM_OE_N(oe_n_a)
    );

    sram_burst_ctrl #(
        .CPU_W(32), .SRAM_DW(16), .SRAM_AW(18), .WAIT_STATES(0), .BURST_MAX(4), .BASE_ADDR(1024)
    ) dut_b (
        .clk(clk), .rst(rst_b), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_len(req_len), .busy(busy_b), .done(done_b),
        .rdata(rdata_b), .rdata_valid(valid_b), .word_idx(widx_b), .SRAM_DQ(sram_dq_b),
        .SRAM_ADDR(addr_b), .SRAM_WE_N(we_n_b), .SRAM_OE_N(oe_n_b)
    );

    // Asynchronous-read SRAM models; the extra driver on bus A probes for a floating bus.
    assign sram_dq_a = (!oe_n_a && we_n_a) ? mem_a[addr_a] : 16'hzzzz;
    assign sram_dq_a = tb_drv_a ? 16'h5A5A : 16'hzzzz;
    assign sram_dq_b = (!oe_n_b && we_n_b) ? mem_b[addr_b] : 16'hzzzz;

    always @(posedge clk) begin
        if (!we_n_a) mem_a[addr_a] <= sram_dq_a;
        if (pre_en)  mem_a[pre_addr] <= pre_data;
    end

    always @(posedge clk) begin
        if (!we_n_b) mem_b[addr_b] <= sram_dq_b;
        if (pre_en)  mem_b[pre_addr] <= pre_data;
    end

    assign o_busy  = use_b ? busy_b  : busy_a;
    assign o_done  = use_b ? done_b  : done_a;
    assign o_valid = use_b ? valid_b : valid_a;
    assign o_we_n  = use_b ? we_n_b  : we_n_a;
    assign o_oe_n  = use_b ? oe_n_b  : oe_n_a;
    assign o_rdata = use_b ? rdata_b : rdata_a;
    assign o_widx  = use_b ? widx_b  : widx_a;
    assign o_addr  = use_b ? addr_b  : addr_a;
    assign o_dq    = use_b ? sram_dq_b : sram_dq_a;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [17:0] addr, input logic [15:0] data);
        pre_en   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        tick();
        pre_en   = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic also_rd, input int ws, input int wa);
        int b;
        req_addr  = addr;
        req_wdata = data;
        req_len   = 3'd1;
        req_wr    = 1'b1;
        req_rd    = also_rd;
        #1;
        check("wr_busy_req", 32'(o_busy), 32'd1);
        for (int cyc = 1; cyc <= 2 * (ws + 1); cyc++) begin
            tick();
            b = (cyc - 1) / (ws + 1);
            check("wr_busy", 32'(o_busy), 32'd1);
            check("wr_we_n", 32'(o_we_n), 32'd0);
            check("wr_oe_n", 32'(o_oe_n), 32'd1);
            check("wr_done", 32'(o_done), 32'd0);
            check("wr_addr", 32'(o_addr), 32'((wa * 2 + b) % 262144));
            check("wr_dq", 32'(o_dq), (b == 1) ? 32'(data[31:16]) : 32'(data[15:0]));
        end
        tick();
        check("wr_done_pulse", 32'(o_done), 32'd1);
        check("wr_busy_done", 32'(o_busy), 32'd0);
        check("wr_we_n_done", 32'(o_we_n), 32'd1);
        check("wr_no_valid", 32'(o_valid), 32'd0);
        req_wr = 1'b0;
        req_rd = 1'b0;
        tick();
        check("wr_done_once", 32'(o_done), 32'd0);
        $display("write addr=%0d data=%h rd_too=%0d", addr, data, also_rd);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [2:0] len,
                           input int nwords, input int ws, input int wa);
        int cpw;
        int k;
        int b;
        cpw      = 2 * (ws + 1);
        req_addr = addr;
        req_len  = len;
        req_rd   = 1'b1;
        #1;
        check("rd_busy_req", 32'(o_busy), 32'd1);
        for (int cyc = 1; cyc <= nwords * cpw; cyc++) begin
            tick();
            k = (cyc - 1) / cpw;
            b = ((cyc - 1) % cpw) / (ws + 1);
            check("rd_busy", 32'(o_busy), 32'd1);
            check("rd_oe_n", 32'(o_oe_n), 32'd0);
            check("rd_we_n", 32'(o_we_n), 32'd1);
            check("rd_done", 32'(o_done), 32'd0);
            check("rd_addr", 32'(o_addr), 32'(((wa + k) * 2 + b) % 262144));
            if (cyc > 1 && ((cyc - 1) % cpw) == 0) begin
                check("rd_valid", 32'(o_valid), 32'd1);
                check("rd_data", o_rdata, exp_w[k - 1]);
                check("rd_widx", 32'(o_widx), 32'(k - 1));
            end else begin
                check("rd_valid_idle", 32'(o_valid), 32'd0);
            end
        end
        tick();
        check("rd_done_pulse", 32'(o_done), 32'd1);
        check("rd_busy_done", 32'(o_busy), 32'd0);
        check("rd_oe_n_done", 32'(o_oe_n), 32'd1);
        check("rd_valid_last", 32'(o_valid), 32'd1);
        check("rd_data_last", o_rdata, exp_w[nwords - 1]);
        check("rd_widx_last", 32'(o_widx), 32'(nwords - 1));
        req_rd = 1'b0;
        tick();
        check("rd_done_once", 32'(o_done), 32'd0);
        check("rd_valid_once", 32'(o_valid), 32'd0);
        check("rd_data_hold", o_rdata, exp_w[nwords - 1]);
        $display("read addr=%0d len=%0d words=%0d last=%h", addr, len, nwords, o_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        clk       = 1'b0;
        rst_a     = 1'b0;
        rst_b     = 1'b0;
        use_b     = 1'b0;
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_len   = 3'd0;
        pre_en    = 1'b0;
        pre_addr  = 18'd0;
        pre_data  = 16'd0;
        tb_drv_a  = 1'b0;
        for (int i = 0; i < 4; i++) exp_w[i] = 32'd0;

        // Reset state, with a request present to show busy is held low.
        tick();
        tick();
        req_rd = 1'b1;
        #1;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_we_n", 32'(o_we_n), 32'd1);
        check("rst_oe_n", 32'(o_oe_n), 32'd1);
        check("rst_addr", 32'(o_addr), 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_widx", 32'(o_widx), 32'd0);
        req_rd = 1'b0;
        rst_a  = 1'b1;
        tick();
        check("post_rst_busy", 32'(o_busy), 32'd0);

        // One wait state: write then read back.
        do_write(32'd1028, 32'hDEADBEEF, 1'b0, 1, 1);
        check("wr_mem2", 32'(mem_a[2]), 32'h0000BEEF);
        check("wr_mem3", 32'(mem_a[3]), 32'h0000DEAD);
        exp_w[0] = 32'hDEADBEEF;
        do_read(32'd1028, 3'd1, 1, 1, 1);

        // Simultaneous read and write: write wins.
        do_write(32'd1032, 32'h12345678, 1'b1, 1, 2);
        check("rdwr_mem4", 32'(mem_a[4]), 32'h00005678);
        check("rdwr_mem5", 32'(mem_a[5]), 32'h00001234);

        // Length 0 reads one word.
        exp_w[0] = 32'h12345678;
        do_read(32'd1032, 3'd0, 1, 1, 2);

        // Top of the SRAM wraps to address 0 for the second word.
        preload(18'd262142, 16'hAAAA);
        preload(18'd262143, 16'hBBBB);
        preload(18'd0, 16'hCCCC);
        preload(18'd1, 16'hDDDD);
        exp_w[0] = 32'hBBBBAAAA;
        exp_w[1] = 32'hDDDDCCCC;
        do_read(32'd525308, 3'd2, 2, 1, 131071);

        // Zero wait states: 4-word burst, then an over-long length clamped to 4.
        for (int i = 0; i < 8; i++) preload(18'(i), 16'(i));
        rst_a = 1'b0;
        rst_b = 1'b1;
        use_b = 1'b1;
        tick();
        exp_w[0] = 32'h00010000;
        exp_w[1] = 32'h00030002;
        exp_w[2] = 32'h00050004;
        exp_w[3] = 32'h00070006;
        do_read(32'd1024, 3'd4, 4, 0, 0);
        do_read(32'd1024, 3'd7, 4, 0, 0);

        // Reset in the middle of a 4-word read.
        rst_b = 1'b0;
        rst_a = 1'b1;
        use_b = 1'b0;
        tick();
        req_addr = 32'd1024;
        req_len  = 3'd4;
        req_rd   = 1'b1;
        tick();
        tick();
        tick();
        check("mid_oe_active", 32'(o_oe_n), 32'd0);
        rst_a  = 1'b0;
        req_rd = 1'b0;
        #1;
        check("mid_busy_now", 32'(o_busy), 32'd0);
        check("mid_oe_now", 32'(o_oe_n), 32'd1);
        tick();
        check("mid_busy", 32'(o_busy), 32'd0);
        check("mid_oe_n", 32'(o_oe_n), 32'd1);
        check("mid_we_n", 32'(o_we_n), 32'd1);
        check("mid_done", 32'(o_done), 32'd0);
        tb_drv_a = 1'b1;
        #1;
        check("mid_dq_float", 32'(o_dq), 32'h00005A5A);
        tb_drv_a = 1'b0;
        rst_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_no_done", 32'(o_done), 32'd0);
            check("mid_idle_busy", 32'(o_busy), 32'd0);
        end
        $display("reset mid-burst released");
        do_write(32'd1036, 32'hCAFEF00D, 1'b0, 1, 3);
        check("after_rst_mem6", 32'(mem_a[6]), 32'h0000F00D);
        check("after_rst_mem7", 32'(mem_a[7]), 32'h0000CAFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
